// File: rtl/not16_arbiter.sv
// not16_arbiter: N_REQ-way arbiter in front of a Not16 (bitwise NOT) datapath.
// Each operation is a 3-cycle IDLE -> EXEC -> ACK sequence.
// Default arbitration is round-robin.
// Defining NOT16_ARB_FIXED_PRIORITY_EN selects fixed priority instead (lowest index wins).
module not16_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     data_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             capture_c;
  logic             complete_c;
  logic             finish_c;
  logic [IDX_W-1:0] win_idx_c;
  logic             win_found_c;
  logic [WIDTH-1:0] win_data_c;
  logic [WIDTH-1:0] operand;
  logic [IDX_W-1:0] cur_idx;

`ifdef NOT16_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the lowest asserted request index wins
  always_comb begin
    win_idx_c   = '0;
    win_found_c = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx_c   = IDX_W'(i);
        win_found_c = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W:0]   cand_c;

  // Round-robin: scan from last_grant+1 (wrapping); the nearest asserted request wins.
  // The loop runs from the farthest offset down to the nearest,
  // so the nearest asserted request writes last and takes priority.
  always_comb begin
    win_idx_c   = '0;
    win_found_c = 1'b0;
    cand_c      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand_c = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand_c >= (IDX_W+1)'(N_REQ)) begin
        cand_c = cand_c - (IDX_W+1)'(N_REQ);
      end
      if (req[cand_c[IDX_W-1:0]]) begin
        win_idx_c   = cand_c[IDX_W-1:0];
        win_found_c = 1'b1;
      end
    end
  end

  // Round-robin pointer: index N_REQ-1 after reset, so requester 0 is searched first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(N_REQ - 1);
    end else if (capture_c) begin
      last_grant <= win_idx_c;
    end
  end
`endif

  // Select the winner's operand slice
  always_comb begin
    win_data_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_c == IDX_W'(i)) begin
        win_data_c = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_nxt  = state;
    capture_c  = 1'b0;
    complete_c = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found_c) begin
          capture_c = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        complete_c = 1'b1;
        state_nxt  = ACK;
      end
      ACK: begin
        finish_c  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner, run the NOT, and drive the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      ack       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      busy      <= 1'b0;
      operand   <= '0;
      cur_idx   <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (capture_c) begin
        grant   <= N_REQ'(1) << win_idx_c;
        operand <= win_data_c;
        cur_idx <= win_idx_c;
      end
      if (complete_c) begin
        out       <= ~operand;
        out_id    <= cur_idx;
        ack       <= grant;
        out_valid <= 1'b1;
      end
      if (finish_c) begin
        grant     <= '0;
        ack       <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_not16_arbiter.sv
// Self-checking bench for not16_arbiter.
// Uses directed cases plus randomized traffic, checked against a request-level model.
// Honours NOT16_ARB_FIXED_PRIORITY_EN the same way the design does.
module tb_not16_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   data_in;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         ack;
  logic [WIDTH-1:0]         out;
  logic                     out_valid;
  logic [IDX_W-1:0]         out_id;
  logic                     busy;

  int n_checks;
  int n_fail;
  int model_last;
  logic [WIDTH-1:0] model_out;

  not16_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .grant(grant), .ack(ack), .out(out), .out_valid(out_valid),
    .out_id(out_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner under the arbitration rule: scan index order from the rule's start point
  function automatic int pick(input logic [N_REQ-1:0] r);
    int idx;
`ifdef NOT16_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < N_REQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (model_last + k) % N_REQ;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_hold"}, 32'(out), 32'(model_out));
  endtask

  // One operation; enters and leaves at a negedge with the DUT in IDLE
  task automatic run_op(input string tag, input logic [N_REQ-1:0] r,
                        input logic [N_REQ*WIDTH-1:0] d, input bit drop,
                        input bit scramble, input bit hold);
    int w;
    logic [WIDTH-1:0] opnd;
    req = r;
    data_in = d;
    w = pick(r);
    opnd = d[w*WIDTH +: WIDTH];
    model_last = w;
    @(negedge clk);
    chk({tag, "_grant"}, 32'(grant), 32'(1) << w);
    chk({tag, "_busy_exec"}, 32'(busy), 32'd1);
    chk({tag, "_ack_exec"}, 32'(ack), 32'd0);
    chk({tag, "_valid_exec"}, 32'(out_valid), 32'd0);
    if (drop) req = '0;
    if (scramble) data_in = {$urandom, $urandom};
    @(negedge clk);
    model_out = ~opnd;
    chk({tag, "_ack"}, 32'(ack), 32'(1) << w);
    chk({tag, "_out"}, 32'(out), 32'(model_out));
    chk({tag, "_out_id"}, 32'(out_id), 32'(w));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_grant_ack"}, 32'(grant), 32'(1) << w);
    if (!hold) req = '0;
    @(negedge clk);
    check_idle({tag, "_end"});
  endtask

  initial begin
    logic [N_REQ-1:0] r;
    n_checks   = 0;
    n_fail     = 0;
    model_last = N_REQ - 1;
    model_out  = '0;
    rst = 1'b1;
    req = '0;
    data_in = '0;
    #1;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_out_id", 32'(out_id), 32'd0);
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 0
    run_op("single", 4'b0001, {16'h0, 16'h0, 16'h0, 16'h00FF}, 1'b0, 1'b0, 1'b0);
    chk("single_out_const", 32'(out), 32'h0000FF00);

    // Idle with no request stays idle
    repeat (3) @(negedge clk);
    check_idle("no_req");

    // Everyone requesting, req held across operations
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("all_%0d", i), 4'b1111, {16'h1234, 16'hAAAA, 16'hFFFF, 16'h0000},
             1'b0, 1'b0, 1'b1);
    end
    req = '0;

    // Reset asserted during EXEC discards the operation
    req = 4'b0010;
    data_in = {16'h0, 16'h0, 16'h5A5A, 16'h0};
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_last = N_REQ - 1;
    model_out  = '0;
    chk("rst_exec_out", 32'(out), 32'd0);
    chk("rst_exec_id", 32'(out_id), 32'd0);
    check_idle("rst_exec");
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(ack), 32'd0);
    end
    run_op("after_rst", 4'b0100, {16'h0, 16'h0F0F, 16'h0, 16'h0}, 1'b0, 1'b0, 1'b0);

    // Early drop of request and operand change during EXEC
    run_op("drop", 4'b0010, {16'h0, 16'h0, 16'h8001, 16'h0}, 1'b1, 1'b0, 1'b0);
    run_op("scramble", 4'b1000, {16'hC3C3, 16'h0, 16'h0, 16'h0}, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_op($sformatf("rand_%0d", i), r, {$urandom, $urandom},
             ($urandom % 4) == 0, ($urandom % 2) == 1, ($urandom % 3) == 0);
      req = '0;
      if (($urandom % 4) == 0) begin
        @(negedge clk);
        check_idle($sformatf("rand_gap_%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
